// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings that double as the controller's
// Control select, and the sequencer state enum. Used by the RTL, the
// controller bench and the host sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    DONE   = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_settle_timer.sv
// Settle down-counter for the ALU command sequencer.
// Ports:
//   Clk, nReset   clock, async active-low reset
//   load_i        load SETTLE_CYCLES-1 (takes priority over dec_i)
//   dec_i         decrement, saturates at 0
//   zero_o        counter == 0
module alu_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic Clk,
  input  logic nReset,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)                      cnt_q <= '0;
    else if (load_i)                  cnt_q <= LOAD_VAL;
    else if (dec_i && (cnt_q != '0))  cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side driver for the ALU result mux. Takes one command per
// handshake, drives Control/OpA/OpB, waits SETTLE_CYCLES edges, captures
// Result_In and presents it on a valid/ready response port.
// Ports:
//   Clk, nReset                      clock, async active-low reset
//   Cmd_Valid/Cmd_Ready              command handshake (ready only in IDLE)
//   Cmd_Op, Cmd_A, Cmd_B, Cmd_Accum  command fields
//   Control, OpA, OpB                drive to the ALU datapath
//   Result_In                        muxed ALU result
//   Rsp_Valid/Rsp_Ready              response handshake
//   Rsp_Data, Rsp_Zero               captured result and its zero flag
//   Busy                             state != IDLE
// Build option: ALU_ACCUM_EN adds an accumulator loaded with every captured
// result; Cmd_Accum=1 then substitutes it for Cmd_A. Without the macro,
// Cmd_Accum is ignored.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic [1:0]       Cmd_Op,
  input  logic [WIDTH-1:0] Cmd_A,
  input  logic [WIDTH-1:0] Cmd_B,
  input  logic             Cmd_Accum,
  output logic [1:0]       Control,
  output logic [WIDTH-1:0] OpA,
  output logic [WIDTH-1:0] OpB,
  input  logic [WIDTH-1:0] Result_In,
  output logic             Rsp_Valid,
  input  logic             Rsp_Ready,
  output logic [WIDTH-1:0] Rsp_Data,
  output logic             Rsp_Zero,
  output logic             Busy
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("alu_cmd_sequencer: SETTLE_CYCLES must be >= 1");
  end

  seq_state_e       state_q, state_d;
  logic [1:0]       ctrl_q;
  logic [WIDTH-1:0] opa_q, opb_q, rsp_data_q, opa_sel;
  logic             rsp_valid_q, rsp_zero_q;
  logic             accept, capture, rsp_pop, tmr_load, tmr_dec, tmr_zero;

  alu_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .Clk    (Clk),
    .nReset (nReset),
    .load_i (tmr_load),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero)
  );

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    rsp_pop  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE: if (Cmd_Valid) begin
        accept   = 1'b1;
        tmr_load = 1'b1;
        state_d  = SETTLE;
      end
      SETTLE: if (tmr_zero) begin
        capture = 1'b1;
        state_d = DONE;
      end else begin
        tmr_dec = 1'b1;
      end
      DONE: if (Rsp_Ready) begin
        rsp_pop = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_ACCUM_EN
  logic [WIDTH-1:0] acc_q;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)      acc_q <= '0;
    else if (capture) acc_q <= Result_In;
  end

  assign opa_sel = Cmd_Accum ? acc_q : Cmd_A;
`else
  logic unused_accum;
  assign unused_accum = Cmd_Accum;
  assign opa_sel      = Cmd_A;
`endif

  // Operand/select registers only load on accept so the datapath stays
  // quiet between commands.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      ctrl_q <= 2'b00;
      opa_q  <= '0;
      opb_q  <= '0;
    end else if (accept) begin
      ctrl_q <= Cmd_Op;
      opa_q  <= opa_sel;
      opb_q  <= Cmd_B;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
    end else if (capture) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= Result_In;
      rsp_zero_q  <= (Result_In == '0);
    end else if (rsp_pop) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign Cmd_Ready = (state_q == IDLE);
  assign Busy      = (state_q != IDLE);
  assign Control   = ctrl_q;
  assign OpA       = opa_q;
  assign OpB       = opb_q;
  assign Rsp_Valid = rsp_valid_q;
  assign Rsp_Data  = rsp_data_q;
  assign Rsp_Zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer (WIDTH=16, SETTLE_CYCLES=2). A behavioural ALU
// drives Result_In from Control/OpA/OpB; expected responses come from a
// command-level model (op arithmetic on the command fields plus a tracked
// last-result accumulator).
module tb_alu_cmd_sequencer;

  localparam int W = 16;
  localparam int SC = 2;

  logic         Clk = 1'b0;
  logic         nReset;
  logic         Cmd_Valid, Cmd_Ready, Cmd_Accum;
  logic [1:0]   Cmd_Op, Control;
  logic [W-1:0] Cmd_A, Cmd_B, OpA, OpB, Result_In, Rsp_Data;
  logic         Rsp_Valid, Rsp_Ready, Rsp_Zero, Busy;

  int vectors = 0;
  int errs    = 0;
  logic [W-1:0] acc_m = '0;

  alu_cmd_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .Clk(Clk), .nReset(nReset),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Op(Cmd_Op),
    .Cmd_A(Cmd_A), .Cmd_B(Cmd_B), .Cmd_Accum(Cmd_Accum),
    .Control(Control), .OpA(OpA), .OpB(OpB), .Result_In(Result_In),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Data(Rsp_Data),
    .Rsp_Zero(Rsp_Zero), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Stand-in for the ALU datapath and output mux.
  always_comb begin
    Result_In = '0;
    case (Control)
      2'b00: Result_In = OpA & OpB;
      2'b01: Result_In = OpA | OpB;
      2'b10: Result_In = OpA + OpB;
      2'b11: Result_In = OpA - OpB;
      default: Result_In = '0;
    endcase
  end

  function automatic logic [W-1:0] ref_alu(input logic [1:0] op,
                                           input logic [W-1:0] a, b);
    int unsigned r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = (a + b) % 65536;
      default: r = (65536 + a - b) % 65536;
    endcase
    return W'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction. hold = cycles Rsp_Ready stays low after Rsp_Valid;
  // probe = offer a second command while the response is pending.
  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] a, b,
                        input logic accum, input int hold, input bit probe);
    logic [W-1:0] ea, er;
`ifdef ALU_ACCUM_EN
    ea = accum ? acc_m : a;
`else
    ea = a;
`endif
    er = ref_alu(op, ea, b);
    @(negedge Clk);
    chk("cmd_ready_idle", Cmd_Ready, 1);
    Cmd_Valid = 1'b1; Cmd_Op = op; Cmd_A = a; Cmd_B = b; Cmd_Accum = accum;
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    chk("busy_after_accept", Busy, 1);
    chk("control", Control, op);
    chk("opa", OpA, ea);
    chk("opb", OpB, b);
    chk("rsp_valid_early", Rsp_Valid, 0);
    for (int i = 1; i < SC; i++) begin
      @(negedge Clk);
      chk("rsp_valid_settle", Rsp_Valid, 0);
    end
    @(negedge Clk);
    chk("rsp_valid", Rsp_Valid, 1);
    chk("rsp_data", Rsp_Data, er);
    chk("rsp_zero", Rsp_Zero, (er == '0));
    for (int i = 0; i < hold; i++) begin
      if (probe) begin
        Cmd_Valid = 1'b1; Cmd_Op = 2'b11; Cmd_A = 16'hAAAA; Cmd_B = 16'h5555;
      end
      @(negedge Clk);
      chk("hold_valid", Rsp_Valid, 1);
      chk("hold_data", Rsp_Data, er);
      chk("hold_cmd_ready", Cmd_Ready, 0);
      chk("hold_control", Control, op);
    end
    Rsp_Ready = 1'b1;
    @(negedge Clk);
    Rsp_Ready = 1'b0;
    Cmd_Valid = 1'b0;
    chk("rsp_popped", Rsp_Valid, 0);
    chk("idle_busy", Busy, 0);
    chk("control_kept", Control, op);
    chk("opb_kept", OpB, b);
    acc_m = er;
  endtask

  initial begin
    nReset = 1'b0; Cmd_Valid = 1'b0; Cmd_Op = 2'b00; Cmd_A = '0; Cmd_B = '0;
    Cmd_Accum = 1'b0; Rsp_Ready = 1'b0;
    #1;
    chk("rst_control", Control, 0);
    chk("rst_rsp_valid", Rsp_Valid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_rsp_data", Rsp_Data, 0);
    chk("rst_rsp_zero", Rsp_Zero, 0);
    @(negedge Clk);
    nReset = 1'b1;
    #1;
    chk("rst_cmd_ready", Cmd_Ready, 1);

    do_cmd(2'b10, 16'h1234, 16'h0001, 1'b0, 0, 1'b0);
    do_cmd(2'b11, 16'h0005, 16'h0005, 1'b0, 1, 1'b0);
    do_cmd(2'b10, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    do_cmd(2'b00, 16'hF0F0, 16'h3C3C, 1'b0, 5, 1'b1);

    // Reset one cycle after accept: response must never appear.
    @(negedge Clk);
    Cmd_Valid = 1'b1; Cmd_Op = 2'b10; Cmd_A = 16'h1111; Cmd_B = 16'h2222; Cmd_Accum = 1'b0;
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    @(negedge Clk);
    nReset = 1'b0;
    #1;
    chk("midrst_busy", Busy, 0);
    chk("midrst_rsp_valid", Rsp_Valid, 0);
    chk("midrst_control", Control, 0);
    chk("midrst_opa", OpA, 0);
    @(negedge Clk);
    nReset = 1'b1;
    acc_m = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("postrst_rsp_valid", Rsp_Valid, 0);
      chk("postrst_busy", Busy, 0);
    end
    do_cmd(2'b01, 16'h00F0, 16'h0F00, 1'b0, 0, 1'b0);

    // Accumulator chain (or Cmd_A pass-through when the option is off).
    do_cmd(2'b10, 16'h0003, 16'h0004, 1'b0, 0, 1'b0);
    do_cmd(2'b10, 16'h0100, 16'h0010, 1'b1, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      do_cmd(2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
